// File: rtl/isa_pd_write_latch.sv
// isa_pd_write_latch: captures ISA high-byte I/O writes into PD with valid/ack handshake and IOCHRDY stretching
module isa_pd_write_latch #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] sd_i,
  input  logic       sa1_i,
  input  logic       aen_i,
  input  logic       iow_n_i,
  output logic       iochrdy_o,
  output logic [7:0] pd_o,
  output logic       pd_valid_o,
  input  logic       pd_ack_i,
  output logic       overrun_o,
  input  logic       ovr_clr_i
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN} state_e;
  state_e           state_q, state_d;
  logic [1:0]       iow_q, sa1_q, aen_q;
  logic             iow_p_q, iow_s, start;
  logic [7:0]       sd1_q, sd_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sd_hold_q, sd_hold_d, pd_q, pd_d;
  logic             pd_valid_q, pd_valid_d, overrun_q, overrun_d, ovr_set;
  assign iow_s = iow_q[1];
  assign start = iow_p_q & ~iow_s & sa1_q[1] & ~aen_q[1];
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      iow_q      <= 2'b11;
      iow_p_q    <= 1'b1;
      sa1_q      <= '0;
      aen_q      <= '0;
      sd1_q      <= '0;
      sd_s_q     <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sd_hold_q  <= '0;
      pd_q       <= '0;
      pd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      iow_q      <= {iow_q[0], iow_n_i};
      iow_p_q    <= iow_s;
      sa1_q      <= {sa1_q[0], sa1_i};
      aen_q      <= {aen_q[0], aen_i};
      sd1_q      <= sd_i;
      sd_s_q     <= sd1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sd_hold_q  <= sd_hold_d;
      pd_q       <= pd_d;
      pd_valid_q <= pd_valid_d;
      overrun_q  <= overrun_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    sd_hold_d  = sd_hold_q;
    pd_d       = pd_q;
    pd_valid_d = pd_valid_q & ~pd_ack_i;
    ovr_set    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = pd_valid_q ? S_WAIT : S_CAPTURE;
      // a host that ignores the wait loses its byte even if the slot just freed
      S_WAIT: begin
        if (iow_s) begin
          ovr_set = 1'b1;
          state_d = S_IDLE;
        end else if (!pd_valid_q) begin
          state_d = S_CAPTURE;
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          ovr_set = 1'b1;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        if (iow_s) begin
          pd_d       = sd_hold_q;
          pd_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          sd_hold_d = sd_s_q;
        end
      end
      S_DRAIN: if (iow_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    overrun_d = ovr_set | (overrun_q & ~ovr_clr_i);
  end
  assign iochrdy_o  = state_q != S_WAIT;
  assign pd_o       = pd_q;
  assign pd_valid_o = pd_valid_q;
  assign overrun_o  = overrun_q;
endmodule

// File: tb/tb_isa_pd_write_latch.sv
// tb_isa_pd_write_latch: scoreboard bench; u_dut uses the default wait limit, u_to a 16-cycle limit
module tb_isa_pd_write_latch;
  logic       clk, rst_n, sa1, aen, iow_n, pd_ack, ovr_clr;
  logic [7:0] sd;
  logic       iochrdy, pd_valid, overrun, t_iochrdy, t_pd_valid, t_overrun;
  logic [7:0] pd, t_pd;
  logic [7:0] exp_q[$];
  int         checks, errors;

  isa_pd_write_latch u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .sd_i(sd), .sa1_i(sa1), .aen_i(aen), .iow_n_i(iow_n),
    .iochrdy_o(iochrdy), .pd_o(pd), .pd_valid_o(pd_valid), .pd_ack_i(pd_ack),
    .overrun_o(overrun), .ovr_clr_i(ovr_clr)
  );
  isa_pd_write_latch #(.WAIT_MAX(16), .CNT_W(8)) u_to (
    .clk_i(clk), .rst_n_i(rst_n), .sd_i(sd), .sa1_i(sa1), .aen_i(aen), .iow_n_i(iow_n),
    .iochrdy_o(t_iochrdy), .pd_o(t_pd), .pd_valid_o(t_pd_valid), .pd_ack_i(pd_ack),
    .overrun_o(t_overrun), .ovr_clr_i(ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_write(input logic [7:0] d, input logic a1, input logic en);
    sd = d; sa1 = a1; aen = en; iow_n = 1'b0;
  endtask

  task automatic expect_commit(input string name);
    int lat;
    logic [7:0] e;
    lat = 0;
    iow_n = 1'b1;
    while (!pd_valid && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (!pd_valid || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_commit: pd_valid=%b queued=%0d after %0d cycles", name, pd_valid, exp_q.size(), lat);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (pd !== e) begin errors++; $display("FAIL %s_data: got %h want %h", name, pd, e); end
      if (lat !== 3) begin errors++; $display("FAIL %s_latency: got %0d want 3", name, lat); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iow_n = 1'b1; sa1 = 1'b0; aen = 1'b0; sd = 8'h00; pd_ack = 1'b0; ovr_clr = 1'b0;
    repeat (3) tick();
    checks += 6;
    if (iochrdy !== 1'b1)    begin errors++; $display("FAIL reset_iochrdy: got %b want 1", iochrdy); end
    if (pd !== 8'h00)        begin errors++; $display("FAIL reset_pd: got %h want 00", pd); end
    if (pd_valid !== 1'b0)   begin errors++; $display("FAIL reset_pd_valid: got %b want 0", pd_valid); end
    if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    if (t_iochrdy !== 1'b1)  begin errors++; $display("FAIL reset_t_iochrdy: got %b want 1", t_iochrdy); end
    if (t_overrun !== 1'b0)  begin errors++; $display("FAIL reset_t_overrun: got %b want 0", t_overrun); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int bad;
    bad = 0;
    exp_q.push_back(8'hA5);
    start_write(8'hA5, 1'b1, 1'b0);
    repeat (8) begin tick(); if (iochrdy !== 1'b1) bad++; end
    expect_commit("single");
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_iochrdy: low for %0d cycles want 0", bad); end
    pd_ack = 1'b1;
    tick();
    pd_ack = 1'b0;
    checks += 2;
    if (pd_valid !== 1'b0) begin errors++; $display("FAIL single_ack: pd_valid got %b want 0", pd_valid); end
    if (pd !== 8'hA5)      begin errors++; $display("FAIL single_retain: pd got %h want a5", pd); end
  endtask

  task automatic test_decode();
    for (int k = 0; k < 2; k++) begin
      start_write(8'h5A, k == 1, k == 1);
      repeat (8) tick();
      iow_n = 1'b1;
      repeat (5) tick();
      checks += 2;
      if (pd_valid !== 1'b0) begin errors++; $display("FAIL decode%0d_valid: got %b want 0", k, pd_valid); end
      if (pd !== 8'hA5)      begin errors++; $display("FAIL decode%0d_pd: got %h want a5", k, pd); end
      sa1 = 1'b1; aen = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic test_stretch();
    int bad;
    bad = 0;
    exp_q.push_back(8'h11);
    start_write(8'h11, 1'b1, 1'b0);
    repeat (8) tick();
    expect_commit("stretch_first");
    exp_q.push_back(8'h22);
    start_write(8'h22, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (iochrdy !== (i < 3)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stretch_wait: %0d cycles wrong iochrdy want 0", bad); end
    pd_ack = 1'b1;
    tick();
    pd_ack = 1'b0;
    checks += 2;
    if (pd_valid !== 1'b0) begin errors++; $display("FAIL stretch_ack: pd_valid got %b want 0", pd_valid); end
    if (iochrdy !== 1'b0)  begin errors++; $display("FAIL stretch_hold: iochrdy got %b want 0", iochrdy); end
    tick();
    checks++;
    if (iochrdy !== 1'b1)  begin errors++; $display("FAIL stretch_release: iochrdy got %b want 1", iochrdy); end
    repeat (2) tick();
    expect_commit("stretch_second");
    checks++;
    if (overrun !== 1'b0)  begin errors++; $display("FAIL stretch_overrun: got %b want 0", overrun); end
    pd_ack = 1'b1;
    tick();
    pd_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int low;
    low = 0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(8'h11);
    start_write(8'h11, 1'b1, 1'b0);
    repeat (8) tick();
    expect_commit("timeout_first");
    checks += 2;
    if (t_pd !== 8'h11)       begin errors++; $display("FAIL timeout_setup_pd: got %h want 11", t_pd); end
    if (t_pd_valid !== 1'b1)  begin errors++; $display("FAIL timeout_setup_valid: got %b want 1", t_pd_valid); end
    start_write(8'h33, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin tick(); if (t_iochrdy === 1'b0) low++; end
    iow_n = 1'b1;
    repeat (4) tick();
    checks += 7;
    if (low != 16)            begin errors++; $display("FAIL timeout_low_cycles: got %0d want 16", low); end
    if (t_overrun !== 1'b1)   begin errors++; $display("FAIL timeout_overrun: got %b want 1", t_overrun); end
    if (t_pd !== 8'h11)       begin errors++; $display("FAIL timeout_pd: got %h want 11", t_pd); end
    if (t_pd_valid !== 1'b1)  begin errors++; $display("FAIL timeout_valid: got %b want 1", t_pd_valid); end
    if (t_iochrdy !== 1'b1)   begin errors++; $display("FAIL timeout_release: got %b want 1", t_iochrdy); end
    if (overrun !== 1'b1)     begin errors++; $display("FAIL ignored_wait_overrun: got %b want 1", overrun); end
    if (pd !== 8'h11)         begin errors++; $display("FAIL ignored_wait_pd: got %h want 11", pd); end
  endtask

  task automatic test_overrun();
    int n;
    n = 0;
    start_write(8'h44, 1'b1, 1'b0);
    while (t_iochrdy === 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (t_iochrdy !== 1'b0) begin errors++; $display("FAIL overrun_enter_wait: iochrdy got %b want 0", t_iochrdy); end
    repeat (15) tick();
    checks++;
    if (t_iochrdy !== 1'b0) begin errors++; $display("FAIL overrun_last_wait: iochrdy got %b want 0", t_iochrdy); end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checks += 2;
    if (t_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins: got %b want 1", t_overrun); end
    if (t_iochrdy !== 1'b1) begin errors++; $display("FAIL overrun_timeout_edge: iochrdy got %b want 1", t_iochrdy); end
    iow_n = 1'b1;
    repeat (4) tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checks += 2;
    if (t_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", t_overrun); end
    if (overrun !== 1'b0)   begin errors++; $display("FAIL overrun_clear_main: got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid_stretch();
    int bad;
    bad = 0;
    start_write(8'h55, 1'b1, 1'b0);
    repeat (5) tick();
    checks++;
    if (iochrdy !== 1'b0) begin errors++; $display("FAIL midrst_wait: iochrdy got %b want 0", iochrdy); end
    rst_n = 1'b0;
    tick();
    checks += 3;
    if (iochrdy !== 1'b1)  begin errors++; $display("FAIL midrst_iochrdy: got %b want 1", iochrdy); end
    if (pd_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", pd_valid); end
    if (pd !== 8'h00)      begin errors++; $display("FAIL midrst_pd: got %h want 00", pd); end
    iow_n = 1'b1;
    rst_n = 1'b1;
    repeat (3) tick();
    exp_q.push_back(8'h3C);
    start_write(8'h3C, 1'b1, 1'b0);
    repeat (8) begin tick(); if (iochrdy !== 1'b1) bad++; end
    expect_commit("midrst_recover");
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_recover_iochrdy: low for %0d cycles want 0", bad); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_write();
    test_decode();
    test_stretch();
    test_timeout();
    test_overrun();
    test_reset_mid_stretch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
